lsu_ctrl: RTL and testbench



---
 rtl/lsu_ctrl_pkg.sv | 50 +++++
 rtl/lsu_extend.sv | 23 ++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: memory function codes, FSM state constants, the latched
// request record and small decode helpers shared by the load/store unit.
package lsu_ctrl_pkg;

    // Memory port function codes (3-bit, shared with the data memory).
    localparam logic [2:0] MEM_LB   = 3'd0;
    localparam logic [2:0] MEM_LH   = 3'd1;
    localparam logic [2:0] MEM_LW   = 3'd2;
    localparam logic [2:0] MEM_LBU  = 3'd3;
    localparam logic [2:0] MEM_LHU  = 3'd4;
    localparam logic [2:0] MEM_SB   = 3'd5;
    localparam logic [2:0] MEM_SH   = 3'd6;
    localparam logic [2:0] MEM_SW   = 3'd7;
    // The idle code is a harmless word read, never a store.
    localparam logic [2:0] MEM_IDLE = MEM_LW;

    // Controller states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Request captured on a misaligned accept and replayed byte by byte.
    typedef struct packed {
        logic [2:0]  fn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  nbytes;
    } lsu_req_t;

    function automatic logic is_store(input logic [2:0] fn);
        return (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
    endfunction

    // Access width in bytes; anything not half/word is a byte access.
    function automatic logic [2:0] access_bytes(input logic [2:0] fn);
        case (fn)
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] fn, input logic [1:0] lsb);
        case (access_bytes(fn))
            3'd4:    return (lsb != 2'b00);
            3'd2:    return lsb[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of raw little-endian load data by function
// code. Store codes produce zero so the response data of a store is 0.
module lsu_extend
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  fn_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    // Select the extension implied by the access type.
    always_comb begin
        case (fn_i)
            MEM_LB:  data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            MEM_LH:  data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            MEM_LW:  data_o = raw_i;
            MEM_LBU: data_o = {24'd0, raw_i[7:0]};
            MEM_LHU: data_o = {16'd0, raw_i[15:0]};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator for the memory stage. Aligned accesses take
// one memory cycle; misaligned half/word accesses are replayed as byte
// accesses while req_ready is held low. Responses appear one cycle after the
// final memory access.
// Build option: define LSU_MISALIGN_TRAP_EN to answer misaligned requests
// with resp_fault instead of splitting them (BUSY then never entered).
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fn,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic [2:0]        mem_fn,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic [0:0]  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_fault_q, resp_fault_d;

    logic [31:0] req_addr32;
    logic        busy;
    logic        req_go;
    logic        req_mis;
    logic [31:0] byte_addr;
    logic [7:0]  store_byte;
    logic        last_byte;
    logic [31:0] asm_merge;
    logic [2:0]  ext_fn;
    logic [31:0] ext_raw;
    logic [31:0] ext_data;

    assign req_addr32 = 32'(req_addr);
    assign busy       = (state_q == ST_BUSY);
    // Reset also silences the memory port so no store can commit while held.
    assign req_go     = req_valid & ~busy & ~reset;
    assign req_mis    = is_misaligned(req_fn, req_addr32[1:0]);
    assign byte_addr  = req_q.addr + {30'd0, cnt_q};
    assign store_byte = req_q.wdata[{cnt_q, 3'b000} +: 8];
    assign last_byte  = ({1'b0, cnt_q} == (req_q.nbytes - 3'd1));

    assign req_ready  = ~busy;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;

    // Merge the byte returned this cycle into the assembly word.
    always_comb begin
        asm_merge = asm_q;
        asm_merge[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
    end

    // One extender serves both the direct aligned path and the assembled word.
    assign ext_fn  = busy ? req_q.fn : req_fn;
    assign ext_raw = busy ? asm_merge : mem_rdata;

    lsu_extend u_extend (
        .fn_i   (ext_fn),
        .raw_i  (ext_raw),
        .data_o (ext_data)
    );

    // Drive the memory port: byte replay when busy, pass-through on accept.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        mem_fn    = MEM_IDLE;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (busy) begin
            mem_fn   = is_store(req_q.fn) ? MEM_SB : MEM_LBU;
            mem_addr = byte_addr;
            if (is_store(req_q.fn)) begin
                mem_wdata = {24'd0, store_byte};
            end
        end else if (req_go) begin
            if (!req_mis) begin
                mem_fn    = req_fn;
                mem_addr  = req_addr32;
                mem_wdata = req_wdata;
            end else begin
`ifndef LSU_MISALIGN_TRAP_EN
                mem_fn   = is_store(req_fn) ? MEM_SB : MEM_LBU;
                mem_addr = req_addr32;
                if (is_store(req_fn)) begin
                    mem_wdata = {24'd0, req_wdata[7:0]};
                end
`endif
            end
        end
    end

    // Next-state, request latch, byte counter and response computation.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'd0;
        resp_fault_d = 1'b0;
        if (busy) begin
            asm_d = asm_merge;
            cnt_d = cnt_q + 2'd1;
            if (last_byte) begin
                state_d      = ST_IDLE;
                cnt_d        = 2'd0;
                resp_valid_d = 1'b1;
                resp_data_d  = ext_data;
            end
        end else if (req_go) begin
            if (!req_mis) begin
                resp_valid_d = 1'b1;
                resp_data_d  = ext_data;
            end else begin
`ifdef LSU_MISALIGN_TRAP_EN
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
`else
                req_d.fn     = req_fn;
                req_d.addr   = req_addr32;
                req_d.wdata  = req_wdata;
                req_d.nbytes = access_bytes(req_fn);
                cnt_d        = 2'd1;
                asm_d        = {24'd0, mem_rdata[7:0]};
                state_d      = ST_BUSY;
`endif
            end
        end
    end

    // State registers; reset aborts any split access immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= 2'd0;
            asm_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl. A byte-array memory answers the
// DUT's port; a transaction-level model predicts, per cycle, the memory
// access, req_ready and response, and one negedge process compares them.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fn;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [2:0]  mem_fn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fn     (req_fn),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_fault (resp_fault),
        .mem_fn     (mem_fn),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- data memory (4 KiB, address wraps) ----------------
    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic        pl_en = 1'b0;
    logic [11:0] pl_a = 12'd0;
    logic [7:0]  pl_d = 8'd0;
    logic [11:0] ma;
    logic [31:0] mword;

    assign ma    = mem_addr[11:0];
    assign mword = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

    always_comb begin
        case (mem_fn)
            MEM_LB:  mem_rdata = {{24{mword[7]}}, mword[7:0]};
            MEM_LH:  mem_rdata = {{16{mword[15]}}, mword[15:0]};
            MEM_LW:  mem_rdata = mword;
            MEM_LBU: mem_rdata = {24'd0, mword[7:0]};
            MEM_LHU: mem_rdata = {16'd0, mword[15:0]};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else begin
            case (mem_fn)
                MEM_SB: mem[ma] <= mem_wdata[7:0];
                MEM_SH: begin
                    mem[ma]         <= mem_wdata[7:0];
                    mem[ma + 12'd1] <= mem_wdata[15:8];
                end
                MEM_SW: begin
                    mem[ma]         <= mem_wdata[7:0];
                    mem[ma + 12'd1] <= mem_wdata[15:8];
                    mem[ma + 12'd2] <= mem_wdata[23:16];
                    mem[ma + 12'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int next_free = 0;
    bit chk_on = 1'b0;
    logic [31:0] last_rd = 32'd0;
    logic        last_rf = 1'b0;
    int          resp_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]  fn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        rf;
    } exp_t;

    localparam int NCYC = 2048;
    exp_t       exp_q [0:NCYC-1];
    logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

    function automatic int nbytes(input logic [2:0] fn);
        if (fn == MEM_LW || fn == MEM_SW) return 4;
        if (fn == MEM_LH || fn == MEM_LHU || fn == MEM_SH) return 2;
        return 1;
    endfunction

    function automatic bit is_st(input logic [2:0] fn);
        return fn >= MEM_SB;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nbytes(fn); i++)
            v = v | (32'(ref_mem[12'(addr + 32'(i))]) << (8 * i));
        if (fn == MEM_LB && v[7])  v = v | 32'hFFFF_FF00;
        if (fn == MEM_LH && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input int n);
        for (int i = 0; i < n; i++)
            ref_mem[12'(addr + 32'(i))] = wd[8*i +: 8];
    endtask

    // ---------------- per-cycle compare ----------------
    exp_t e;
    always @(negedge clk) begin
        if (chk_on && !reset && cyc < NCYC) begin
            e = exp_q[cyc];
            check("mem_fn",     32'(mem_fn),     32'(e.fn));
            check("mem_addr",   mem_addr,        e.addr);
            check("mem_wdata",  mem_wdata,       e.wd);
            check("req_ready",  32'(req_ready),  32'(e.rdy));
            check("resp_valid", 32'(resp_valid), 32'(e.rv));
            if (e.rv) begin
                check("resp_data",  resp_data,       e.rd);
                check("resp_fault", 32'(resp_fault), 32'(e.rf));
            end
            if (resp_valid) begin
                last_rd  = resp_data;
                last_rf  = resp_fault;
                resp_cyc = cyc;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        ref_mem[a] = d;
        step();
        pl_en = 1'b0;
    endtask

    // Issue one request; when noise is set, a stray store is offered while
    // the DUT is busy and must be ignored.
    task automatic issue(input logic [2:0] fn, input logic [31:0] addr,
                         input logic [31:0] wd, input bit noise);
        int c, n, sz;
        bit mis;
        logic [31:0] rsp;
        while (cyc < next_free) step();
        c   = cyc;
        sz  = nbytes(fn);
        mis = (addr % 32'(sz)) != 0;
        n   = 1;
        if (!mis) begin
            exp_q[c].fn   = fn;
            exp_q[c].addr = addr;
            exp_q[c].wd   = wd;
            if (is_st(fn)) begin
                model_store(addr, wd, sz);
                rsp = 32'd0;
            end else begin
                rsp = model_load(fn, addr);
            end
            exp_q[c+1].rv = 1'b1;
            exp_q[c+1].rd = rsp;
            exp_q[c+1].rf = 1'b0;
        end else if (TRAP) begin
            exp_q[c+1].rv = 1'b1;
            exp_q[c+1].rd = 32'd0;
            exp_q[c+1].rf = 1'b1;
        end else begin
            n = sz;
            for (int i = 0; i < sz; i++) begin
                exp_q[c+i].fn   = is_st(fn) ? MEM_SB : MEM_LBU;
                exp_q[c+i].addr = addr + 32'(i);
                exp_q[c+i].wd   = is_st(fn) ? {24'd0, wd[8*i +: 8]} : 32'd0;
                exp_q[c+i].rdy  = (i == 0);
            end
            if (is_st(fn)) begin
                model_store(addr, wd, sz);
                rsp = 32'd0;
            end else begin
                rsp = model_load(fn, addr);
            end
            exp_q[c+sz].rv = 1'b1;
            exp_q[c+sz].rd = rsp;
            exp_q[c+sz].rf = 1'b0;
        end
        req_valid = 1'b1;
        req_fn    = fn;
        req_addr  = addr;
        req_wdata = wd;
        for (int i = 1; i < n; i++) begin
            step();
            req_valid = noise;
            req_fn    = MEM_SW;
            req_addr  = 32'h0000_03F0;
            req_wdata = 32'h1234_5678;
        end
        step();
        req_valid = 1'b0;
        req_fn    = MEM_LW;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        next_free = c + n;
    endtask

    // Wait for the last issued response and pin it to hand-computed values.
    task automatic expect_resp(input string name, input logic [31:0] d, input logic f);
        while (cyc < next_free) step();
        @(negedge clk);
        #1;
        check({name, "_when"},  32'(resp_cyc), 32'(next_free));
        check({name, "_data"},  last_rd, d);
        check({name, "_fault"}, 32'(last_rf), 32'(f));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_q[i] = '{fn: MEM_IDLE, addr: 32'd0, wd: 32'd0, rdy: 1'b1,
                         rv: 1'b0, rd: 32'd0, rf: 1'b0};
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        req_fn    = MEM_LW;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        #2;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data",  resp_data,       32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_fn",     32'(mem_fn),     32'(MEM_LW));
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        repeat (3) step();
        reset  = 1'b0;
        chk_on = 1'b1;

        // Aligned word load.
        poke(12'h100, 8'h11); poke(12'h101, 8'h22);
        poke(12'h102, 8'h33); poke(12'h103, 8'h44); poke(12'h104, 8'h55);
        issue(MEM_LW, 32'h100, 32'd0, 1'b0);
        expect_resp("lw100", 32'h4433_2211, 1'b0);

        // Misaligned word load split into four byte reads, stray request ignored.
        issue(MEM_LW, 32'h101, 32'd0, 1'b1);
        expect_resp("lw101", TRAP ? 32'd0 : 32'h5544_3322, TRAP);

        // Misaligned halfword, signed and unsigned.
        poke(12'h103, 8'h34); poke(12'h104, 8'hF2);
        issue(MEM_LH, 32'h103, 32'd0, 1'b0);
        expect_resp("lh103", TRAP ? 32'd0 : 32'hFFFF_F234, TRAP);
        issue(MEM_LHU, 32'h103, 32'd0, 1'b0);
        expect_resp("lhu103", TRAP ? 32'd0 : 32'h0000_F234, TRAP);

        // Misaligned word store, read back with aligned loads.
        issue(MEM_SW, 32'h202, 32'hDEAD_BEEF, 1'b1);
        expect_resp("sw202", 32'd0, TRAP);
        issue(MEM_LW, 32'h200, 32'd0, 1'b0);
        expect_resp("lw200", TRAP ? 32'd0 : 32'hBEEF_0000, 1'b0);
        issue(MEM_LW, 32'h204, 32'd0, 1'b0);
        expect_resp("lw204", TRAP ? 32'd0 : 32'h0000_DEAD, 1'b0);

        // Byte loads never split.
        poke(12'h107, 8'h9C);
        issue(MEM_LB, 32'h107, 32'd0, 1'b0);
        expect_resp("lb107", 32'hFFFF_FF9C, 1'b0);
        issue(MEM_LBU, 32'h107, 32'd0, 1'b0);
        expect_resp("lbu107", 32'h0000_009C, 1'b0);

        // Back-to-back aligned traffic, one accept per cycle.
        issue(MEM_SH, 32'h210, 32'h1234_ABCD, 1'b0);
        issue(MEM_LHU, 32'h212, 32'd0, 1'b0);
        issue(MEM_LH, 32'h210, 32'd0, 1'b0);
        expect_resp("lh210", 32'hFFFF_ABCD, 1'b0);

        // Misaligned halfword store straddling the previous halfword.
        issue(MEM_SH, 32'h211, 32'h0000_BEEF, 1'b1);
        issue(MEM_LHU, 32'h211, 32'd0, 1'b0);
        expect_resp("lhu211", TRAP ? 32'd0 : 32'h0000_BEEF, TRAP);
        issue(MEM_LW, 32'h210, 32'd0, 1'b0);
        expect_resp("lw210", TRAP ? 32'h0000_ABCD : 32'h00BE_EFCD, 1'b0);

        // Byte address wraps past the top of the 32-bit space.
        poke(12'hFFF, 8'hA1); poke(12'h000, 8'hB2);
        poke(12'h001, 8'hC3); poke(12'h002, 8'hD4);
        issue(MEM_LW, 32'hFFFF_FFFF, 32'd0, 1'b0);
        expect_resp("lw_wrap", TRAP ? 32'd0 : 32'hD4C3_B2A1, TRAP);

        // Store aborted by reset during its second byte.
        if (!TRAP) begin
            while (cyc < next_free) step();
            exp_q[cyc].fn     = MEM_SB;
            exp_q[cyc].addr   = 32'h301;
            exp_q[cyc].wd     = 32'h0000_00DD;
            exp_q[cyc+1].fn   = MEM_SB;
            exp_q[cyc+1].addr = 32'h302;
            exp_q[cyc+1].wd   = 32'h0000_00CC;
            exp_q[cyc+1].rdy  = 1'b0;
            model_store(32'h301, 32'h0000_00DD, 1);
            req_valid = 1'b1;
            req_fn    = MEM_SW;
            req_addr  = 32'h301;
            req_wdata = 32'hAABB_CCDD;
            step();
            @(negedge clk);
            #1;
            reset     = 1'b1;
            req_valid = 1'b0;
            #1;
            check("abort_req_ready",  32'(req_ready),  32'd1);
            check("abort_resp_valid", 32'(resp_valid), 32'd0);
            check("abort_mem_fn",     32'(mem_fn),     32'(MEM_IDLE));
            @(posedge clk);
            #1;
            reset     = 1'b0;
            next_free = cyc + 3;
        end else begin
            issue(MEM_SW, 32'h301, 32'hAABB_CCDD, 1'b0);
            expect_resp("sw301_trap", 32'd0, 1'b1);
        end
        issue(MEM_LW, 32'h300, 32'd0, 1'b0);
        expect_resp("lw300", TRAP ? 32'd0 : 32'h0000_DD00, 1'b0);
        issue(MEM_LW, 32'h304, 32'd0, 1'b0);
        expect_resp("lw304", 32'd0, 1'b0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
